imem_loader: RTL and testbench

Boot-time program loader upstream of the single-cycle CPU top.
- Accepts a byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a word-addressed write port. Addresses match the CPU fetch index pc[12:2].
- Holds the CPU in reset until a complete, valid image has been loaded, then releases it.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_word_packer.sv | 32 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM states, sync marker, imem geometry.
// Shared with the CPU top for the instruction-memory word-address width.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_LEN_W  = 16;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid pulses the cycle after the 4th byte is taken.
module imem_loader_byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  byte_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_valid <= 1'b0;
      byte_idx   <= '0;
    end else if (clear) begin
      word       <= '0;
      word_valid <= 1'b0;
      byte_idx   <= '0;
    end else begin
      word_valid <= byte_valid && (byte_idx == 2'd3);
      if (byte_valid) begin
        word[{byte_idx, 3'b000} +: 8] <= byte_data;
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: UART bytes -> imem words, then releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = imem_loader_pkg::IMEM_ADDR_W,
  parameter int         LEN_W     = imem_loader_pkg::IMEM_LEN_W,
  parameter logic [7:0] SYNC_BYTE = imem_loader_pkg::SYNC_BYTE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  words_q;
  logic [1:0]        byte_idx;
  logic              hs;
  logic              data_hs;
  logic              last_byte;

  assign hs        = rx_valid & rx_ready;
  assign data_hs   = hs && (state_q == DATA);
  assign len_full  = LEN_W'({rx_data, count_q[7:0]});
  // words_q already counts every earlier word when a 4th byte lands
  assign last_byte = data_hs && (byte_idx == 2'd3) &&
                     (words_q + LEN_W'(1) == count_q);

  assign imem_addr    = addr_q;
  assign words_loaded = words_q;

  imem_loader_byte_word_packer u_packer (
    .clk        (clock),
    .rst_n      (reset),
    .clear      (state_q != DATA),
    .byte_data  (rx_data),
    .byte_valid (data_hs),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .byte_idx   (byte_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       csum_q <= '0;
    else if (data_hs) csum_q <= csum_q ^ rx_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:   if (hs && rx_data == SYNC_BYTE) state_d = LEN_LO;
      LEN_LO: if (hs) state_d = LEN_HI;
      LEN_HI: begin
        if (hs) begin
          if (len_full == '0)
            state_d = RUN;
          else if ({1'b0, len_full} > MAX_WORDS)
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA:   if (last_byte) state_d = AFTER_DATA;
      CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (hs) state_d = (rx_data == csum_q) ? RUN : ERR;
`endif
      end
      default: ;
    endcase
  end

  // Release is held off while the final word's write is still in flight
  always_comb begin
    rx_ready  = 1'b0;
    cpu_run   = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    unique case (state_q)
      SYNC, LEN_LO, LEN_HI, DATA, CSUM: rx_ready = 1'b1;
      RUN: begin
        cpu_run   = ~imem_we;
        load_done = ~imem_we;
      end
      ERR:     load_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
    end else begin
      if (hs && state_q == LEN_LO) count_q[7:0] <= rx_data;
      if (hs && state_q == LEN_HI) count_q <= len_full;
      if (imem_we) begin
        words_q <= words_q + LEN_W'(1);
        if (addr_q != '1) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; both checksum builds.
// Writes are logged at negedge and compared against hand values.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [10:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  always #5 clock = ~clock;

  imem_loader dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          not_ready = 0;
  logic [7:0]  stim[$];
  logic [7:0]  csum;
  logic [10:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clock) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    if (i < wr_addr.size()) return 32'(wr_addr[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] wd(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 'x;
  endfunction

  task automatic hdr(input int n);
    stim.push_back(8'hA5);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    csum = '0;
  endtask

  task automatic word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      stim.push_back(w[8*k +: 8]);
      csum ^= w[8*k +: 8];
    end
  endtask

  task automatic tail();
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(csum);
`endif
  endtask

  task automatic send(input bit gap);
    foreach (stim[i]) begin
      @(negedge clock);
      if (!rx_ready) not_ready++;
      rx_data  = stim[i];
      rx_valid = 1'b1;
      if (gap) begin
        @(negedge clock);
        rx_valid = 1'b0;
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
    stim.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic settle();
    repeat (4) @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_cpu_run", 32'(cpu_run), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_err", 32'(load_err), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_words", 32'(words_loaded), 0);
    reset = 1'b1;

    // two-word image, back-to-back
    hdr(2);
    word(32'h0000_0013);
    word(32'h0000_0008);
    tail();
    send(1'b0);
    settle();
    check("a_nwr", 32'(wr_addr.size()), 2);
    check("a_addr0", wa(0), 0);
    check("a_data0", wd(0), 32'h0000_0013);
    check("a_addr1", wa(1), 1);
    check("a_data1", wd(1), 32'h0000_0008);
    check("a_run", 32'(cpu_run), 1);
    check("a_done", 32'(load_done), 1);
    check("a_err", 32'(load_err), 0);
    check("a_words", 32'(words_loaded), 2);
    check("a_ready", 32'(rx_ready), 0);

    stim.push_back(8'hA5);
    stim.push_back(8'h01);
    send(1'b1);
    settle();
    check("a_ign_words", 32'(words_loaded), 2);
    check("a_ign_nwr", 32'(wr_addr.size()), 2);

    // leading junk, gapped bytes
    do_reset();
    stim.push_back(8'h00);
    stim.push_back(8'hFF);
    hdr(1);
    word(32'hDEAD_BEEF);
    tail();
    send(1'b1);
    settle();
    check("b_nwr", 32'(wr_addr.size()), 1);
    check("b_addr0", wa(0), 0);
    check("b_data0", wd(0), 32'hDEAD_BEEF);
    check("b_run", 32'(cpu_run), 1);

    #2 reset = 1'b0;
    #1 check("async_rst_run", 32'(cpu_run), 0);
    check("async_rst_done", 32'(load_done), 0);

    // zero-length image
    do_reset();
    hdr(0);
    send(1'b0);
    settle();
    check("z_run", 32'(cpu_run), 1);
    check("z_words", 32'(words_loaded), 0);
    check("z_nwr", 32'(wr_addr.size()), 0);

    // count 2049 rejected
    do_reset();
    stim.push_back(8'hA5);
    stim.push_back(8'h01);
    stim.push_back(8'h08);
    send(1'b0);
    settle();
    check("e_err", 32'(load_err), 1);
    check("e_run", 32'(cpu_run), 0);
    check("e_ready", 32'(rx_ready), 0);
    check("e_nwr", 32'(wr_addr.size()), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    hdr(1);
    word(32'h4433_2211);
    stim.push_back(8'h00);
    send(1'b0);
    settle();
    check("c_bad_nwr", 32'(wr_addr.size()), 1);
    check("c_bad_data", wd(0), 32'h4433_2211);
    check("c_bad_err", 32'(load_err), 1);
    check("c_bad_run", 32'(cpu_run), 0);

    do_reset();
    hdr(1);
    word(32'h4433_2211);
    stim.push_back(8'h44);
    send(1'b0);
    settle();
    check("c_ok_run", 32'(cpu_run), 1);
    check("c_ok_err", 32'(load_err), 0);
`endif

    // reset after two data bytes, then a clean reload
    do_reset();
    stim.push_back(8'hA5);
    stim.push_back(8'h01);
    stim.push_back(8'h00);
    stim.push_back(8'hAA);
    stim.push_back(8'hBB);
    send(1'b1);
    check("m_partial_nwr", 32'(wr_addr.size()), 0);
    do_reset();
    hdr(1);
    word(32'h0403_0201);
    tail();
    send(1'b0);
    settle();
    check("m_nwr", 32'(wr_addr.size()), 1);
    check("m_addr0", wa(0), 0);
    check("m_data0", wd(0), 32'h0403_0201);

    // eight words with rx_valid held high
    do_reset();
    not_ready = 0;
    hdr(8);
    for (int i = 0; i < 8; i++) word(32'hC0DE_0000 | 32'(i));
    tail();
    send(1'b0);
    settle();
    check("s_nwr", 32'(wr_addr.size()), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s_addr%0d", i), wa(i), 32'(i));
      check($sformatf("s_data%0d", i), wd(i), 32'hC0DE_0000 | 32'(i));
    end
    check("s_stall", 32'(not_ready), 0);
    check("s_run", 32'(cpu_run), 1);
    check("s_words", 32'(words_loaded), 8);

    // full 2048-word image hits the top address
    do_reset();
    hdr(2048);
    for (int i = 0; i < 2048; i++) word(32'h5A00_0000 ^ 32'(i));
    tail();
    send(1'b0);
    settle();
    check("f_nwr", 32'(wr_addr.size()), 2048);
    check("f_addr_mid", wa(1024), 1024);
    check("f_addr_last", wa(2047), 2047);
    check("f_data_last", wd(2047), 32'h5A00_07FF);
    check("f_words", 32'(words_loaded), 2048);
    check("f_run", 32'(cpu_run), 1);
    check("f_err", 32'(load_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
